// File: rtl/chu_uart_poll_sched.sv
// chu_uart_poll_sched: round-robin query/reply poller over N_CH UART FIFO ports on the FPro slot bus.
// Define POLL_STATS_EN to add saturating per-channel timeout counters in RESP[c][31:16].
module chu_uart_poll_sched #(
   parameter int N_CH = 3,
   parameter int TO_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cs,
   input  logic              read,
   input  logic              write,
   input  logic [4:0]        addr,
   input  logic [31:0]       wr_data,
   output logic [31:0]       rd_data,
   output logic [N_CH-1:0]   wr_uart,
   output logic [8*N_CH-1:0] w_data,
   input  logic [N_CH-1:0]   tx_full,
   output logic [N_CH-1:0]   rd_uart,
   input  logic [8*N_CH-1:0] r_data,
   input  logic [N_CH-1:0]   rx_empty
);
   localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
   typedef enum logic [2:0] {IDLE, WAIT, SEL, FLUSH, SEND, RESP, NEXT} state_t;
   state_t state, state_nxt;
   logic en, en_w, load_p, rx_rdy, tx_go, got, expire, unused_bits;
   logic [N_CH-1:0] mask, served, avail, upd_v, upd_t, clr, resp_v, resp_t;
   logic [CW-1:0] ch, pick;
   logic [23:0] period, pcnt;
   logic [TO_W-1:0] tmo, tcnt;
   logic [7:0] query, rx_byte;
   logic [7:0] resp_byte [N_CH];
   logic [15:0] stat [N_CH];

   // a CTRL write clearing EN takes effect on the very next state
   assign en_w = (cs && write && addr == 5'd0) ? wr_data[0] : en;
   assign avail = mask & ~served;
   assign rx_rdy = !rx_empty[ch];
   assign rx_byte = r_data[{ch, 3'b000} +: 8];
   assign tx_go = state == SEND && !tx_full[ch];
   assign got = state == RESP && rx_rdy;
   assign expire = state == RESP && !rx_rdy && tcnt <= TO_W'(1);
   assign unused_bits = ^wr_data[31:24];

   always_comb begin
      pick = '0;
      for (int i = N_CH - 1; i >= 0; i--) if (avail[i]) pick = CW'(i);
   end

   always_comb begin
      wr_uart = '0;
      rd_uart = '0;
      w_data = '0;
      wr_uart[ch] = tx_go;
      rd_uart[ch] = (state == FLUSH || state == RESP) && rx_rdy;
      w_data[{ch, 3'b000} +: 8] = tx_go ? query : 8'h00;
   end

   always_comb begin
      state_nxt = state;
      load_p = 1'b0;
      case (state)
         IDLE: begin state_nxt = WAIT; load_p = 1'b1; end
         WAIT: if (pcnt <= 24'd1) begin state_nxt = |mask ? SEL : WAIT; load_p = ~|mask; end
         SEL: begin state_nxt = |avail ? FLUSH : WAIT; load_p = ~|avail; end
         FLUSH: state_nxt = rx_rdy ? FLUSH : SEND;
         SEND: state_nxt = tx_go ? RESP : SEND;
         RESP: state_nxt = (got || expire) ? NEXT : RESP;
         NEXT: begin state_nxt = |avail ? SEL : WAIT; load_p = ~|avail; end
         default: state_nxt = IDLE;
      endcase
      if (!en_w) state_nxt = IDLE;
   end

   always_comb begin
      upd_v = '0;
      upd_t = '0;
      clr = '0;
      for (int c = 0; c < N_CH; c++) begin
         upd_v[c] = got && ch == CW'(c);
         upd_t[c] = expire && ch == CW'(c);
         clr[c] = cs && read && addr == 5'(4 + c);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         en <= 1'b0;
         mask <= '0;
         period <= '0;
         tmo <= '0;
         query <= '0;
         pcnt <= '0;
         tcnt <= '0;
         ch <= '0;
         served <= '0;
         resp_v <= '0;
         resp_t <= '0;
         for (int c = 0; c < N_CH; c++) resp_byte[c] <= '0;
      end else begin
         state <= state_nxt;
         if (cs && write) begin
            if (addr == 5'd0) {mask, en} <= wr_data[N_CH:0];
            if (addr == 5'd1) period <= wr_data[23:0];
            if (addr == 5'd2) tmo <= wr_data[TO_W-1:0];
            if (addr == 5'd3) query <= wr_data[7:0];
         end
         pcnt <= load_p ? (period == '0 ? 24'd1 : period) : pcnt - 24'(state == WAIT);
         tcnt <= tx_go ? (tmo == '0 ? TO_W'(1) : tmo) : tcnt - TO_W'(state == RESP);
         served <= state == WAIT ? '0 : state == SEL ? served | (N_CH'(1) << pick) : served;
         ch <= state_nxt == IDLE ? '0 : state == SEL ? pick : ch;
         // hardware updates take priority over clear-on-read
         for (int c = 0; c < N_CH; c++) begin
            if (upd_v[c]) begin
               resp_byte[c] <= rx_byte;
               resp_v[c] <= 1'b1;
            end else if (upd_t[c]) begin
               resp_t[c] <= 1'b1;
            end else if (clr[c]) begin
               resp_byte[c] <= '0;
               resp_v[c] <= 1'b0;
               resp_t[c] <= 1'b0;
            end
         end
      end
   end

`ifdef POLL_STATS_EN
   always_ff @(posedge clk) begin
      for (int c = 0; c < N_CH; c++) begin
         if (reset) stat[c] <= '0;
         else if (upd_t[c]) stat[c] <= stat[c] + 16'(stat[c] != 16'hFFFF);
         else if (clr[c] && !upd_v[c]) stat[c] <= '0;
      end
   end
`else
   always_comb begin
      for (int c = 0; c < N_CH; c++) stat[c] = '0;
   end
`endif

   always_comb begin
      rd_data = '0;
      case (addr)
         5'd0: rd_data = 32'({mask, en});
         5'd1: rd_data = 32'(period);
         5'd2: rd_data = 32'(tmo);
         5'd3: rd_data = 32'(query);
         5'd15: rd_data = 32'({3'(ch), 1'b0, state});
         default: for (int c = 0; c < N_CH; c++) if (addr == 5'(4 + c)) rd_data = {stat[c], 6'd0, resp_t[c], resp_v[c], resp_byte[c]};
      endcase
   end
endmodule

// File: doc/chu_uart_poll_sched.md
# chu_uart_poll_sched

MMIO-slot controller that sequences request/response polling over the three pmod UART links driving the actuators. Every poll period it walks the enabled channels round-robin, sends a query byte on each, waits for a one-byte reply with timeout, and latches reply and timeout status into per-channel registers read by firmware. It sits on the FPro slot bus. It connects to each UART core's FIFO-side interface (wr_uart/w_data/tx_full, rd_uart/r_data/rx_empty) in place of the per-link bus slots.

## Interface
- N_CH, 3: number of UART channels (1..8).
- TO_W, 16: timeout counter width.
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- cs, read, write  in  1 each  slot select and strobes.
- addr  in  5  register word address.
- wr_data  in  32  write data.
- rd_data  out  32  read data, combinational from addr.
- wr_uart  out  N_CH  one-cycle TX FIFO push per channel.
- w_data  out  8*N_CH  TX byte; channel c uses bits [8c+7:8c].
- tx_full  in  N_CH  TX FIFO full.
- rd_uart  out  N_CH  one-cycle RX FIFO pop per channel.
- r_data  in  8*N_CH  RX FIFO head byte, valid while rx_empty=0.
- rx_empty  in  N_CH  RX FIFO empty.

## Operation
- Registers (word addr):
  - 0 CTRL (R/W): bit0 EN; bits[N_CH:1] channel mask.
  - 1 PERIOD (R/W): [23:0], cycles between rounds; 0 is treated as 1.
  - 2 TIMEOUT (R/W): [TO_W-1:0], reply wait in cycles; 0 is treated as 1.
  - 3 QUERY (R/W): [7:0], byte sent on every channel.
  - 4..4+N_CH-1 RESP[c] (R, clear-on-read):
    - [7:0] last reply byte.
    - bit8 VALID.
    - bit9 TIMEOUT (sticky).
    - [31:16] timeout count (see Configuration).
  - 15 STATUS (R): [2:0] state; [6:4] current channel.
  - Unmapped addresses read 0. Writes to read-only or unmapped addresses are ignored.
- FSM states:
  - IDLE(0): enter WAIT(1) when EN=1; the period counter loads at entry.
  - WAIT(1): count PERIOD cycles. At the end, go to SEL(2) if mask≠0; otherwise reload and remain in WAIT.
  - SEL(2): pick the lowest enabled channel not yet served this round. Go to FLUSH(3).
  - FLUSH(3): while rx_empty[c]=0, pulse rd_uart[c] and discard the stale byte. When empty, go to SEND(4).
  - SEND(4): wait while tx_full[c]=1. Then pulse wr_uart[c] for one cycle with w_data=QUERY, load the timeout counter, and go to RESP(5).
  - RESP(5):
    - If rx_empty[c]=0: pulse rd_uart[c], latch r_data into RESP[c][7:0], set VALID, go to NEXT(6).
    - Else if the timeout counter expires: set TIMEOUT (and the stats count), go to NEXT.
  - NEXT(6): go to SEL if any unserved enabled channel remains; otherwise go to WAIT with the counter reloaded.
- Clearing EN in any state: next state is IDLE and no further pulses are issued. A pulse already issued in the same cycle completes.
- The mask is sampled at SEL. A channel removed mid-round is skipped; a channel added joins the next round.
- A reply arriving in the same cycle as timeout expiry counts as the reply: VALID is set, TIMEOUT is not.
- A RESP[c] read (cs & read) in the same cycle as a hardware update of that register: the update wins and the flags remain set.

## Timing
- Reset values:
  - All outputs 0; wr_uart, rd_uart and w_data are 0.
  - State IDLE; all registers 0.
- w_data is driven only during the wr_uart pulse and is 0 otherwise.
- SEND→RESP: exactly one cycle of wr_uart when tx_full=0.
- Reply latency: the reply is latched in the first RESP cycle with rx_empty=0, and rd_uart pulses in that same cycle.
- Timeout: TIMEOUT is set T cycles after the SEND pulse, where T=TIMEOUT.
- Round start spacing: PERIOD cycles from WAIT entry to SEL.
- At most one rd_uart or wr_uart bit is high in any cycle.

## Configuration
- POLL_STATS_EN defined:
  - RESP[c][31:16] is a 16-bit count of timeouts on channel c.
  - The count saturates at 0xFFFF and clears on read of RESP[c].
- POLL_STATS_EN undefined: bits [31:16] read 0 and no counters are synthesized.

## Test plan
- Single reply:
  - Stimulus: PERIOD=100, TIMEOUT=50, QUERY=0xA5, mask=0b001, EN=1; channel-0 model replies 0x3C 10 cycles after the push.
  - Required: one wr_uart[0] pulse with w_data=0xA5; RESP0 reads 0x13C; a second read returns 0.
- Timeout:
  - Stimulus: mask=0b010, no reply.
  - Required: TIMEOUT set exactly 50 cycles after the push; RESP1 reads 0x200. With POLL_STATS_EN, [31:16]=1 after one round and 3 after three.
- Round-robin:
  - Stimulus: mask=0b111, all channels reply.
  - Required: pushes occur in order 0,1,2 within one round, the next round starts PERIOD cycles after NEXT, and push signals never overlap.
- Stale flush and backpressure:
  - Stimulus: preload 2 stale bytes in RX0; hold tx_full[0]=1 for 20 cycles.
  - Required: 2 discard pops, then the push only after tx_full drops; the latched reply is the fresh byte.
- Race cases:
  - Reply arrives in the exact expiry cycle: VALID=1, TIMEOUT=0.
  - EN cleared during RESP: next state is IDLE and STATUS reads 0.
  - reset asserted mid-round: all outputs 0 in the next cycle.
